// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core constants and boot-controller state encoding.
package mips_pkg;
  localparam int WORDS_INSTRUCTION = 16;
  localparam int INSTRUCTION_WIDTH = 32;
  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_RUN_S,
    BOOT_RECV,
    BOOT_WRITE,
    BOOT_CHECK,
    BOOT_ERROR
  } boot_state_t;
endpackage

// File: rtl/im_boot_ctrl_if.sv
// im_boot_ctrl_if: byte link, load control and instruction-memory port of the boot controller.
interface im_boot_ctrl_if import mips_pkg::*; #(
  parameter int ADDR_W = $clog2(WORDS_INSTRUCTION),
  parameter int DATA_W = INSTRUCTION_WIDTH
);
  logic              load_start;
  logic [ADDR_W:0]   load_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              err;
  modport master (
    output load_start, load_words, byte_valid, byte_data, fetch_addr,
    input  byte_ready, im_addr, im_we, im_wdata, cpu_rst_n, busy, err
  );
  modport slave (
    input  load_start, load_words, byte_valid, byte_data, fetch_addr,
    output byte_ready, im_addr, im_we, im_wdata, cpu_rst_n, busy, err
  );
endinterface

// File: rtl/im_boot_ctrl.sv
// im_boot_ctrl: loads a checksummed big-endian byte image into instruction memory,
// then hands the read port to fetch and releases the core.
module im_boot_ctrl import mips_pkg::*; #(
  parameter logic BOOT_RUN = 1'b1,
  parameter int   ADDR_W   = $clog2(WORDS_INSTRUCTION)
) (
  input logic          clk,
  input logic          rst_n,
  im_boot_ctrl_if.slave bus
);
  localparam boot_state_t RST_S = BOOT_RUN ? BOOT_RUN_S : BOOT_IDLE;
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(WORDS_INSTRUCTION);
  boot_state_t                  r_state, w_next;
  logic [ADDR_W-1:0]            r_wr_ptr;
  logic [ADDR_W:0]              r_words;
  logic [1:0]                   r_byte_cnt;
  logic [7:0]                   r_csum;
  logic [INSTRUCTION_WIDTH-1:0] r_word;
  logic                         w_take, w_start, w_last;
  assign w_take  = bus.byte_valid && bus.byte_ready;
  assign w_start = bus.load_start && (r_state inside {BOOT_IDLE, BOOT_RUN_S, BOOT_ERROR});
  assign w_last  = {1'b0, r_wr_ptr} == r_words - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= RST_S;
    else r_state <= w_next;
  always_comb begin
    w_next         = r_state;
    bus.byte_ready = r_state inside {BOOT_RECV, BOOT_CHECK};
    bus.busy       = r_state inside {BOOT_RECV, BOOT_WRITE, BOOT_CHECK};
    bus.err        = r_state == BOOT_ERROR;
    bus.cpu_rst_n  = r_state == BOOT_RUN_S;
    bus.im_we      = r_state == BOOT_WRITE;
    bus.im_addr    = r_state == BOOT_WRITE ? r_wr_ptr : bus.fetch_addr;
    bus.im_wdata   = r_word;
    unique case (r_state)
      BOOT_IDLE, BOOT_RUN_S, BOOT_ERROR:
        if (bus.load_start)
          w_next = bus.load_words > MAX_WORDS ? BOOT_ERROR :
                   bus.load_words == '0       ? BOOT_CHECK : BOOT_RECV;
      BOOT_RECV:  if (w_take && r_byte_cnt == 2'd3) w_next = BOOT_WRITE;
      BOOT_WRITE: w_next = w_last ? BOOT_CHECK : BOOT_RECV;
      BOOT_CHECK: if (w_take) w_next = bus.byte_data == r_csum ? BOOT_RUN_S : BOOT_ERROR;
      default:    w_next = RST_S;
    endcase
  end
  // First byte of each word lands in the top byte after four shifts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_words    <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
      r_word     <= '0;
    end else begin
      if (w_start) begin
        r_wr_ptr   <= '0;
        r_words    <= bus.load_words;
        r_byte_cnt <= '0;
        r_csum     <= '0;
      end
      if (r_state == BOOT_RECV && w_take) begin
        r_word     <= {r_word[INSTRUCTION_WIDTH-9:0], bus.byte_data};
        r_csum     <= r_csum + bus.byte_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (r_state == BOOT_WRITE) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_byte_cnt <= '0;
      end
    end
endmodule

// File: tb/tb_im_boot_ctrl.sv
// tb_im_boot_ctrl: directed checks of boot loading on a run-at-reset and an idle-at-reset instance.
module tb_im_boot_ctrl;
  import mips_pkg::*;
  localparam int AW = $clog2(WORDS_INSTRUCTION);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_err = 0, n_chk = 0, nw = 0, rdy_viol = 0, a_we = 0;
  logic [AW-1:0] wa [8];
  logic [31:0]   wd [8];
  im_boot_ctrl_if bus_a ();
  im_boot_ctrl_if bus_b ();
  assign bus_b.load_start = bus_a.load_start;
  assign bus_b.load_words = bus_a.load_words;
  assign bus_b.byte_valid = bus_a.byte_valid;
  assign bus_b.byte_data  = bus_a.byte_data;
  assign bus_b.fetch_addr = bus_a.fetch_addr;
  im_boot_ctrl #(.BOOT_RUN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  im_boot_ctrl #(.BOOT_RUN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus_b.im_we) begin
      if (nw < 8) begin
        wa[nw] = bus_b.im_addr;
        wd[nw] = bus_b.im_wdata;
      end
      nw++;
      if (bus_b.byte_ready) rdy_viol++;
    end
    if (bus_a.im_we) a_we++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [AW:0] n);
    bus_a.load_start = 1'b1;
    bus_a.load_words = n;
    @(negedge clk);
    bus_a.load_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic hold);
    int t = 0;
    bus_a.byte_valid = 1'b1;
    bus_a.byte_data  = b;
    while (!bus_b.byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", bus_b.byte_ready, 1);
    @(negedge clk);
    bus_a.byte_valid = hold;
  endtask
  initial begin
    bus_a.load_start = 1'b0;
    bus_a.load_words = '0;
    bus_a.byte_valid = 1'b0;
    bus_a.byte_data  = '0;
    bus_a.fetch_addr = AW'(5);
    repeat (2) @(negedge clk);
    chk("rst_b_cpu", bus_b.cpu_rst_n, 0);
    chk("rst_a_cpu", bus_a.cpu_rst_n, 1);
    chk("rst_b_busy", bus_b.busy, 0);
    chk("rst_b_err", bus_b.err, 0);
    chk("rst_b_ready", bus_b.byte_ready, 0);
    chk("rst_b_we", bus_b.im_we, 0);
    chk("rst_b_wdata", bus_b.im_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("run_a_cpu", bus_a.cpu_rst_n, 1);
    chk("run_a_addr", bus_a.im_addr, 5);
    chk("idle_b_addr", bus_b.im_addr, 5);
    chk("idle_b_cpu", bus_b.cpu_rst_n, 0);
    repeat (3) @(negedge clk);
    #2 chk("run_a_no_we", a_we, 0);
    // Good two-word image
    @(negedge clk);
    nw = 0;
    start(2);
    chk("ld_busy", bus_b.busy, 1);
    chk("ld_ready", bus_b.byte_ready, 1);
    chk("ld_a_cpu_fall", bus_a.cpu_rst_n, 0);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h01, 0);
    chk("wr_we", bus_b.im_we, 1);
    chk("wr_addr", bus_b.im_addr, 0);
    chk("wr_data", bus_b.im_wdata, 32'h2008_0001);
    chk("wr_ready", bus_b.byte_ready, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h29, 0);
    chk("ok_cpu", bus_b.cpu_rst_n, 1);
    chk("ok_err", bus_b.err, 0);
    chk("ok_busy", bus_b.busy, 0);
    chk("ok_a_cpu", bus_a.cpu_rst_n, 1);
    #2;
    chk("ok_nw", nw, 2);
    chk("ok_wa0", wa[0], 0);
    chk("ok_wd0", wd[0], 32'h2008_0001);
    chk("ok_wa1", wa[1], 1);
    chk("ok_wd1", wd[1], 32'h0);
    // Bad checksum, then an empty load clears err
    @(negedge clk);
    start(2);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h2A, 0);
    chk("bad_err", bus_b.err, 1);
    chk("bad_cpu", bus_b.cpu_rst_n, 0);
    chk("bad_busy", bus_b.busy, 0);
    repeat (2) @(negedge clk);
    chk("bad_sticky", bus_b.err, 1);
    nw = 0;
    start(0);
    chk("empty_err_clr", bus_b.err, 0);
    chk("empty_ready", bus_b.byte_ready, 1);
    send(8'h00, 0);
    chk("empty_cpu", bus_b.cpu_rst_n, 1);
    #2 chk("empty_nw", nw, 0);
    @(negedge clk);
    start((AW+1)'(WORDS_INSTRUCTION + 1));
    chk("big_err", bus_b.err, 1);
    chk("big_busy", bus_b.busy, 0);
    chk("big_cpu", bus_b.cpu_rst_n, 0);
    // Continuous byte_valid across WRITE cycles
    nw = 0;
    rdy_viol = 0;
    start(2);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1);
    send(8'h55, 1); send(8'h66, 1); send(8'h77, 1); send(8'h88, 1);
    send(8'h64, 0);
    chk("cont_cpu", bus_b.cpu_rst_n, 1);
    #2;
    chk("cont_nw", nw, 2);
    chk("cont_wd0", wd[0], 32'h1122_3344);
    chk("cont_wd1", wd[1], 32'h5566_7788);
    chk("cont_wa1", wa[1], 1);
    chk("cont_rdy", rdy_viol, 0);
    // Reset in the middle of a word
    @(negedge clk);
    nw = 0;
    start(2);
    send(8'h20, 0); send(8'h08, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_cpu", bus_b.cpu_rst_n, 0);
    chk("mid_busy", bus_b.busy, 0);
    chk("mid_we", bus_b.im_we, 0);
    chk("mid_ready", bus_b.byte_ready, 0);
    chk("mid_addr", bus_b.im_addr, 5);
    chk("mid_a_cpu", bus_a.cpu_rst_n, 1);
    rst_n = 1'b1;
    @(negedge clk);
    start(2);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h29, 0);
    chk("re_cpu", bus_b.cpu_rst_n, 1);
    chk("re_err", bus_b.err, 0);
    #2;
    chk("re_nw", nw, 2);
    chk("re_wa0", wa[0], 0);
    chk("re_wd0", wd[0], 32'h2008_0001);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
